// File: rtl/fsm_input_conditioner_pkg.sv
// Shared types and defaults for the two-channel input synchroniser/debouncer.
package fsm_input_conditioner_pkg;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned DEB_W_DEF       = 4;
  localparam int unsigned DEB_CNT_DEF     = 4;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } chan_state_e;

  // Legal parameter set: at least two sync flops, and DEB_CNT fits in the counter.
  function automatic logic params_ok(input int unsigned sync_stages,
                                     input int unsigned deb_w,
                                     input int unsigned deb_cnt);
    return (sync_stages >= 2) && (deb_cnt >= 1) &&
           (deb_cnt <= ((32'd1 << deb_w) - 32'd1));
  endfunction

endpackage

// File: rtl/fsm_input_conditioner_debounce_chan.sv
// One channel: synchroniser chain, debounce FSM with hold counter, rising-edge strobe.
module fsm_input_conditioner_debounce_chan
  import fsm_input_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned DEB_W       = DEB_W_DEF,
  parameter int unsigned DEB_CNT     = DEB_CNT_DEF
) (
  input  logic clk,
  input  logic res,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_pend_nxt_c
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CNT - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  chan_state_e            r_state;
  chan_state_e            w_state_nxt;
  logic [DEB_W-1:0]       r_cnt;
  logic [DEB_W-1:0]       w_cnt_nxt;
  logic                   r_level;
  logic                   w_level_nxt;
  logic                   r_rise;
  logic                   w_rise_nxt;
  logic                   w_s;

  // Plain shift chain, nothing between stages.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state <= ST_STABLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
    end
  end

  // A new level commits only after DEB_CNT consecutive mismatching synced samples.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    case (r_state)
      ST_STABLE: begin
        w_cnt_nxt = '0;
        if (w_s != r_level) begin
          if (DEB_CNT == 1) begin
            w_level_nxt = w_s;
            w_rise_nxt  = w_s;
          end else begin
            w_state_nxt = ST_PENDING;
            w_cnt_nxt   = DEB_W'(1);
          end
        end
      end
      ST_PENDING: begin
        if (w_s == r_level) begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
          w_level_nxt = w_s;
          w_rise_nxt  = w_s;
        end else begin
          w_cnt_nxt = r_cnt + DEB_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_STABLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_level      = r_level;
  assign o_rise       = r_rise;
  assign o_pend_nxt_c = (w_state_nxt == ST_PENDING);

endmodule

// File: rtl/fsm_input_conditioner.sv
// Conditions raw async inputs x_in/y_in into clean levels and rising-edge strobes.
module fsm_input_conditioner
  import fsm_input_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned DEB_W       = DEB_W_DEF,
  parameter int unsigned DEB_CNT     = DEB_CNT_DEF
) (
  input  logic clk,
  input  logic res,
  input  logic x_in,
  input  logic y_in,
  output logic x,
  output logic y,
  output logic x_edge,
  output logic y_edge,
  output logic busy
);

  if (!params_ok(SYNC_STAGES, DEB_W, DEB_CNT)) begin : g_bad_params
    $error("fsm_input_conditioner: illegal SYNC_STAGES/DEB_W/DEB_CNT combination");
  end

  logic w_x_pend_nxt;
  logic w_y_pend_nxt;
  logic r_busy;

  fsm_input_conditioner_debounce_chan #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_W       (DEB_W),
    .DEB_CNT     (DEB_CNT)
  ) u_chan_x (
    .clk          (clk),
    .res          (res),
    .i_raw        (x_in),
    .o_level      (x),
    .o_rise       (x_edge),
    .o_pend_nxt_c (w_x_pend_nxt)
  );

  fsm_input_conditioner_debounce_chan #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_W       (DEB_W),
    .DEB_CNT     (DEB_CNT)
  ) u_chan_y (
    .clk          (clk),
    .res          (res),
    .i_raw        (y_in),
    .o_level      (y),
    .o_rise       (y_edge),
    .o_pend_nxt_c (w_y_pend_nxt)
  );

  // Registered from next-state so busy tracks the channel state flops exactly.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= w_x_pend_nxt | w_y_pend_nxt;
    end
  end

  assign busy = r_busy;

endmodule

// File: tb/tb_fsm_input_conditioner.sv
// Self-checking bench for fsm_input_conditioner against a run-length reference model.
module tb_fsm_input_conditioner;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned DEB_W       = 4;
  localparam int unsigned DEB_CNT     = 4;

  logic clk = 1'b0;
  logic res;
  logic x_in;
  logic y_in;
  logic x;
  logic y;
  logic x_edge;
  logic y_edge;
  logic busy;

  int n_checks = 0;
  int n_fail   = 0;

  fsm_input_conditioner #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_W       (DEB_W),
    .DEB_CNT     (DEB_CNT)
  ) dut (
    .clk    (clk),
    .res    (res),
    .x_in   (x_in),
    .y_in   (y_in),
    .x      (x),
    .y      (y),
    .x_edge (x_edge),
    .y_edge (y_edge),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Reference: raw samples delayed SYNC_STAGES edges, then a run length of
  // consecutive mismatches; a run of DEB_CNT commits the new level.
  logic [1:0] m_q[$];
  bit         m_lvl[2];
  int         m_run[2];
  bit         m_rise[2];
  bit         m_busy;

  function automatic void model_reset();
    m_q = {};
    for (int i = 0; i < int'(SYNC_STAGES); i++) m_q.push_back(2'b00);
    for (int c = 0; c < 2; c++) begin
      m_lvl[c]  = 1'b0;
      m_run[c]  = 0;
      m_rise[c] = 1'b0;
    end
    m_busy = 1'b0;
  endfunction

  function automatic void model_step();
    logic [1:0] s;
    if (res !== 1'b1) begin
      model_reset();
      return;
    end
    s = m_q.pop_front();
    m_q.push_back({y_in, x_in});
    for (int c = 0; c < 2; c++) begin
      m_rise[c] = 1'b0;
      if (s[c] != m_lvl[c]) begin
        m_run[c]++;
        if (m_run[c] == int'(DEB_CNT)) begin
          m_lvl[c]  = s[c];
          m_rise[c] = s[c];
          m_run[c]  = 0;
        end
      end else begin
        m_run[c] = 0;
      end
    end
    m_busy = (m_run[0] > 0) || (m_run[1] > 0);
  endfunction

  function automatic logic [4:0] model_vec();
    return {m_lvl[0], m_lvl[1], m_rise[0], m_rise[1], m_busy};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    for (int k = 0; k < 8; k++) begin
      x_in = 1'($urandom);
      y_in = 1'($urandom);
      cycle();
      obs = {x, y, x_edge, y_edge, busy};
      n_checks++;
      if (obs !== 5'b00000) begin
        n_fail++;
        $display("FAIL reset_hold k=%0d {x,y,xe,ye,busy} got %b want 00000", k, obs);
      end
    end
    x_in = 1'b0;
    y_in = 1'b0;
    res  = 1'b1;
    repeat (8) cycle();
    obs = {x, y, x_edge, y_edge, busy};
    n_checks++;
    if (obs !== model_vec()) begin
      n_fail++;
      $display("FAIL reset_release {x,y,xe,ye,busy} got %b want %b", obs, model_vec());
    end
  endtask

  task automatic test_rise();
    logic [2:0] obs;
    logic [2:0] exp;
    x_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      obs = {x, x_edge, busy};
      exp = {1'(k >= 5), 1'(k == 5), 1'(k >= 2 && k <= 4)};
      n_checks++;
      if (obs !== exp || {x, y, x_edge, y_edge, busy} !== model_vec()) begin
        n_fail++;
        $display("FAIL rise edge=%0d {x,xe,busy} got %b want %b (model %b)", k, obs, exp, model_vec());
      end
    end
  endtask

  task automatic test_fall();
    logic [2:0] obs;
    logic [2:0] exp;
    x_in = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      obs = {x, x_edge, busy};
      exp = {1'(k < 5), 1'b0, 1'(k >= 2 && k <= 4)};
      n_checks++;
      if (obs !== exp || {x, y, x_edge, y_edge, busy} !== model_vec()) begin
        n_fail++;
        $display("FAIL fall edge=%0d {x,xe,busy} got %b want %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_glitch();
    bit saw_busy = 1'b0;
    x_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) x_in = 1'b0;
      cycle();
      if (busy === 1'b1) saw_busy = 1'b1;
      n_checks++;
      if ({x, x_edge} !== 2'b00 || {x, y, x_edge, y_edge, busy} !== model_vec()) begin
        n_fail++;
        $display("FAIL glitch edge=%0d {x,xe,busy} got %b%b%b want 00%b", k, x, x_edge, busy, m_busy);
      end
    end
    n_checks++;
    if (!saw_busy || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_busy saw_busy=%0b final busy=%b want saw_busy=1 busy=0", saw_busy, busy);
    end
  endtask

  task automatic test_both();
    logic [3:0] obs;
    logic [3:0] exp;
    x_in = 1'b1;
    y_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      obs = {x, y, x_edge, y_edge};
      exp = {1'(k >= 5), 1'(k >= 5), 1'(k == 5), 1'(k == 5)};
      n_checks++;
      if (obs !== exp || busy !== m_busy) begin
        n_fail++;
        $display("FAIL both edge=%0d {x,y,xe,ye} got %b want %b busy=%b", k, obs, exp, busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    x_in = 1'b0;
    y_in = 1'b0;
    repeat (8) cycle();
    x_in = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    res = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({x, y, x_edge, y_edge, busy} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_mid_async {x,y,xe,ye,busy} got %b%b%b%b%b want 00000", x, y, x_edge, y_edge, busy);
    end
    cycle();
    res = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      n_checks++;
      if (x !== 1'(k >= 5) || x_edge !== 1'(k == 5) || {x, y, x_edge, y_edge, busy} !== model_vec()) begin
        n_fail++;
        $display("FAIL reset_mid_release edge=%0d x=%b xe=%b want x=%0b xe=%0b", k, x, x_edge, k >= 5, k == 5);
      end
    end
  endtask

  task automatic test_boundary();
    int holds[6] = '{4, 3, 4, 4, 3, 5};
    int commits = 0;
    for (int h = 0; h < 6; h++) begin
      x_in = ~x_in;
      y_in = 1'($urandom);
      for (int k = 0; k < holds[h]; k++) begin
        cycle();
        if (x_edge === 1'b1) commits++;
        n_checks++;
        if ({x, y, x_edge, y_edge, busy} !== model_vec()) begin
          n_fail++;
          $display("FAIL boundary hold=%0d k=%0d got %b%b%b%b%b want %b", holds[h], k, x, y, x_edge, y_edge, busy, model_vec());
        end
      end
    end
  endtask

  task automatic test_random();
    int hold_x = 0;
    int hold_y = 0;
    for (int k = 0; k < 400; k++) begin
      if (hold_x == 0) begin
        x_in   = 1'($urandom);
        hold_x = int'($urandom_range(1, 7));
      end
      if (hold_y == 0) begin
        y_in   = 1'($urandom);
        hold_y = int'($urandom_range(1, 7));
      end
      hold_x--;
      hold_y--;
      cycle();
      n_checks++;
      if ({x, y, x_edge, y_edge, busy} !== model_vec()) begin
        n_fail++;
        $display("FAIL random cyc=%0d {x,y,xe,ye,busy} got %b%b%b%b%b want %b", k, x, y, x_edge, y_edge, busy, model_vec());
      end
    end
  endtask

  initial begin
    res  = 1'b0;
    x_in = 1'b0;
    y_in = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_rise();
    test_fall();
    test_glitch();
    test_both();
    test_reset_mid();
    test_boundary();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
